mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Load/store sequencer for a word-organised data memory with
//               sub-word read-modify-write and alignment/range checking.
// Revision    : 1.0
// ============================================================================
module mem_access_ctrl #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_WE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RD   = 2'd1;
    localparam logic [1:0]  S_WR   = 2'd2;
    localparam logic [1:0]  S_RESP = 2'd3;
    localparam logic [31:0] C_MEM_WORDS = 32'(MEM_WORDS);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;

    logic        w_err;
    logic [31:0] w_merged;
    logic [31:0] w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (req_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = req_addr[0];
            2'b10:   w_err = |req_addr[1:0];
            default: w_err = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= C_MEM_WORDS) begin
            w_err = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = w_err;
                    if (w_err) begin
                        state_d = S_RESP;
                    end else if (req_we && (req_size == 2'b10)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                word_d  = mem_RD;
                state_d = we_q ? S_WR : S_RESP;
            end
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Little-endian lanes: byte lane is addr[1:0], half lane is addr[1].
    always_comb begin
        w_merged = word_q;
        case (size_q)
            2'b00:   w_merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   w_merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: w_merged = wdata_q;
        endcase
    end

    always_comb begin
        w_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
        w_half = word_q[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   w_load = {{24{~uns_q & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~uns_q & w_half[15]}}, w_half};
            default: w_load = word_q;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign stall      = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = ((state_q == S_RESP) && !we_q && !err_q) ? w_load : 32'd0;

    // Reset gates the strobe combinationally so an interrupted write never lands.
    assign mem_WE = (state_q == S_WR) && !rst;
    assign mem_A  = ((state_q == S_RD) || (state_q == S_WR)) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_WD = (state_q == S_WR) ? w_merged : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Randomised bench for mem_access_ctrl with a transaction-level
//               memory model and per-cycle bus monitor.
// Revision    : 1.0
// ============================================================================
module tb_mem_access_ctrl;

    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, stall, resp_valid, resp_err, mem_WE;
    logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;

    mem_access_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .stall(stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    // Attached data memory and the independent transaction-level copy.
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    assign mem_RD = mem[mem_A[11:2]];
    always @(posedge clk) if (mem_WE) mem[mem_A[11:2]] <= mem_WD;

    int n_tests = 0;
    int n_fail  = 0;

    logic        mon_en    = 1'b0;
    logic        exp_armed = 1'b0;
    logic [31:0] exp_a, exp_wd;
    int          we_count;

    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("stall_vs_ready", {31'd0, stall}, {31'd0, ~req_ready});
            if (!stall) check("idle_bus", mem_A | mem_WD, 32'd0);
            if (mem_WE) begin
                we_count++;
                check("wr_armed", {31'd0, exp_armed}, 32'd1);
                check("wr_addr", mem_A, exp_a);
                check("wr_data", mem_WD, exp_wd);
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned idx;
        logic        err;
        logic [31:0] mask, old, newv, v;
        int          sh, lat, k;
        logic        got, busy_bad;

        idx  = addr >> 2;
        err  = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
               (size == 2'd2 && addr[1:0] != 2'b00) || (idx >= MEM_WORDS);
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        sh   = int'(addr[1:0]) * 8;
        old  = err ? 32'd0 : ref_mem[idx];
        newv = (old & ~(mask << sh)) | ((wdata & mask) << sh);
        v    = (old >> sh) & mask;
        if (!uns && size != 2'd2 && v[(8 << size) - 1]) v = v | ~mask;
        if (err || we) v = 32'd0;
        lat  = err ? 1 : (!we ? 2 : (size == 2'd2 ? 2 : 3));

        exp_armed = we && !err;
        exp_a     = {addr[31:2], 2'b00};
        exp_wd    = newv;
        we_count  = 0;

        @(negedge clk);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        @(posedge clk);

        got = 1'b0; busy_bad = 1'b0; last_lat = 0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!stall || req_ready) busy_bad = 1'b1;
            if (resp_valid) begin
                got = 1'b1; last_lat = k;
                last_rdata = resp_rdata; last_err = resp_err;
                req_valid = 1'b0;
                break;
            end
            // Junk on the request bus while busy must be ignored.
            req_valid = 1'b1; req_we = 1'($urandom); req_size = 2'($urandom);
            req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        end
        req_valid = 1'b0;
        check("resp_seen", {31'd0, got}, 32'd1);
        check("latency", 32'(last_lat), 32'(lat));
        check("busy_flags", {31'd0, busy_bad}, 32'd0);
        check("resp_err", {31'd0, last_err}, {31'd0, err});
        check("resp_rdata", last_rdata, v);
        check("we_pulses", 32'(we_count), exp_armed ? 32'd1 : 32'd0);
        if (we && !err) ref_mem[idx] = newv;
        exp_armed = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          bad;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_bus", {31'd0, mem_WE} | mem_A | mem_WD, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hAABBCCDD);
        check("sw_lat_lit", 32'(last_lat), 32'd2);
        check("sw_mem_lit", mem[4], 32'hAABBCCDD);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055);
        check("sb_lat_lit", 32'(last_lat), 32'd3);
        check("sb_mem_lit", mem[4], 32'hAABB55DD);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
        check("lb_lit", last_rdata, 32'hFFFFFFAA);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
        check("lbu_lit", last_rdata, 32'h000000AA);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
        check("lhu_lit", last_rdata, 32'h0000AABB);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
        check("lh_lit", last_rdata, 32'hFFFFAABB);
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234);
        check("sh_mem_lit", mem[4], 32'h123455DD);
        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'd0);
        check("lw_mis_err_lit", {31'd0, last_err}, 32'd1);
        check("lw_mis_lat_lit", 32'(last_lat), 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'd0);
        check("size11_err_lit", {31'd0, last_err}, 32'd1);
        do_req(1'b1, 2'd2, 1'b0, 32'(4 * MEM_WORDS), 32'hDEADBEEF);
        check("oor_err_lit", {31'd0, last_err}, 32'd1);
        check("oor_rdata_lit", last_rdata, 32'd0);

        // Reset landing in the middle of a write cycle.
        exp_armed = 1'b1; exp_a = 32'h20; exp_wd = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midwr_we_high", {31'd0, mem_WE}, 32'd1);
        #2 rst = 1'b1;
        #1 check("midwr_we_forced", {31'd0, mem_WE}, 32'd0);
        @(negedge clk);
        check("midwr_no_resp", {31'd0, resp_valid}, 32'd0);
        check("midwr_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        exp_armed = 1'b0;
        check("midwr_mem_kept", mem[8], ref_mem[8]);
        @(negedge clk);
        check("midwr_no_resp2", {31'd0, resp_valid}, 32'd0);

        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'(MEM_WORDS * 4) + ($urandom & 32'hFFFF);
                1:       a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                default: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            endcase
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end

        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem_words_bad", 32'(bad), 32'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
